pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipelined core (`pipeline_top`).
- Generates EX-stage operand forwarding selects, load-use stalls, taken-branch flushes and whole-pipe freezes while the data memory is busy.
- Owns the memory-wait/timeout FSM and saturating stall/flush performance counters.
- Sits beside the stage registers and drives their enable/clear inputs.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of each performance counter.
- TIMEOUT, 15, maximum MEM_WAIT cycles before declaring a memory error (≥1).

Ports:
- clk  in  1  Core clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- id_rs1, id_rs2  in  REG_AW  Source registers of the instruction in ID.
- ex_rs1, ex_rs2  in  REG_AW  Source registers of the instruction in EX.
- ex_rd  in  REG_AW  Destination register of the instruction in EX.
- ex_mem_read  in  1  Instruction in EX is a load.
- ex_branch_taken  in  1  Branch/jump in EX resolved taken.
- mem_rd  in  REG_AW  Destination register in MEM.
- mem_reg_write  in  1  Instruction in MEM writes the register file.
- wb_rd  in  REG_AW  Destination register in WB.
- wb_reg_write  in  1  Instruction in WB writes the register file.
- dmem_req  in  1  MEM stage is accessing data memory this cycle.
- dmem_ready  in  1  Data memory completes the access this cycle.
- err_clr  in  1  Clears the ERR state.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB result, 10 MEM result.
- stall_f, stall_d, stall_e, stall_m  out  1  Hold the PC / IF-ID / ID-EX / EX-MEM registers.
- flush_d, flush_e  out  1  Clear IF-ID / ID-EX to a bubble.
- mem_err  out  1  High while in ERR.
- stall_cycles  out  CNT_W  Cycles with stall_f=1.
- flush_events  out  CNT_W  Cycles with a branch flush.

Behaviour:
- **Reset:** rst=1 forces every output to 0 combinationally, puts the FSM in RUN, and clears the wait counter and both performance counters.
- **Forwarding (combinational, independent of FSM):**
  - fwd_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1.
  - Otherwise fwd_a=01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1.
  - Otherwise fwd_a=00.
  - fwd_b is identical using ex_rs2.
  - MEM has priority over WB. Register 0 is never forwarded.
- **Hazard terms:**
  - freeze = (state!=RUN) || (dmem_req && !dmem_ready).
  - load_use = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- **Output priority (combinational, same cycle):**
  1. freeze: stall_f/d/e/m=1; flush_d=flush_e=0.
  2. else ex_branch_taken: flush_d=flush_e=1; all stalls 0. A simultaneous load_use is ignored because the dependent instruction is being flushed.
  3. else load_use: stall_f=stall_d=1, flush_e=1, stall_e=stall_m=0. This gives a one-bubble latency.
  4. else all control outputs 0.
- **FSM states:** RUN, MEM_WAIT, ERR.
  - RUN: dmem_req && !dmem_ready → MEM_WAIT, wait_cnt←1. Otherwise stay.
  - MEM_WAIT: dmem_ready → RUN, wait_cnt←0 (the freeze releases in the cycle after ready is seen). Else if wait_cnt==TIMEOUT → ERR. Else wait_cnt+1.
  - ERR: mem_err=1, freeze held. err_clr → RUN, wait_cnt←0. dmem_ready is ignored in ERR.
- **Performance counters:**
  - stall_cycles increments every cycle stall_f=1 (freeze or load-use).
  - flush_events increments every cycle the branch flush path is taken.
  - Both saturate at all-ones and never wrap.
  - err_clr does not clear them; only rst does.
- **Asynchronous reset mid-MEM_WAIT or mid-ERR:** immediate return to RUN with all outputs 0.

Test Plan:
- Forwarding: ex_rs1=5, mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1 → fwd_a=10. Deassert mem_reg_write → fwd_a=01. Set ex_rs1=0 with all matches → fwd_a=00.
- Load-use: ex_mem_read=1, ex_rd=7, id_rs2=7 for one cycle → stall_f=stall_d=flush_e=1 that cycle; stall_cycles goes 0→1. With ex_rd=0 → no stall.
- Branch priority: ex_branch_taken=1 together with the load_use condition → flush_d=flush_e=1, stall_f=0; flush_events +1, stall_cycles unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 → all stalls=1 for 4 cycles (3 waiting plus the ready cycle), state back to RUN, stall_cycles=4. A branch asserted during the wait yields no flush.
- Timeout: TIMEOUT=3, dmem_ready held 0 → ERR entered after cycle 4, mem_err=1, stalls held. err_clr pulse → RUN, mem_err=0, counters preserved.
- Reset/saturation: rst asserted mid-MEM_WAIT → outputs 0 without a clock edge. With CNT_W=4, 20 load-use cycles → stall_cycles=15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-controller signal bundle between pipeline stages and the controller
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic              ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write;
    logic              dmem_req, dmem_ready, err_clr;
    logic [1:0]        fwd_a, fwd_b;
    logic              stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_err;
    logic [CNT_W-1:0]  stall_cycles, flush_events;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
               ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write,
               dmem_req, dmem_ready, err_clr,
        input  fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               mem_err, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
               ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write,
               dmem_req, dmem_ready, err_clr,
        output fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               mem_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, load-use stall, branch flush, memory-wait freeze and perf counters
module pipeline_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input logic clk,
    input logic rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t           state, state_nx;
    logic [WW-1:0]    wait_cnt, wait_nx;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             freeze, load_use, br, lu;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, m_rd, w_rd, input logic m_we, w_we);
        return (m_we && m_rd != '0 && m_rd == rs) ? 2'b10 :
               (w_we && w_rd != '0 && w_rd == rs) ? 2'b01 : 2'b00;
    endfunction

    // State register and memory-wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    // Next state: enter wait on a stalled access, leave on ready, give up after TIMEOUT cycles
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        case (state)
            RUN: if (bus.dmem_req && !bus.dmem_ready) begin
                state_nx = MEM_WAIT;
                wait_nx  = WW'(1);
            end
            MEM_WAIT: if (bus.dmem_ready) begin
                state_nx = RUN;
                wait_nx  = '0;
            end else if (wait_cnt == WW'(TIMEOUT)) begin
                state_nx = ERR;
            end else begin
                wait_nx = wait_cnt + WW'(1);
            end
            default: if (bus.err_clr) begin
                state_nx = RUN;
                wait_nx  = '0;
            end
        endcase
    end

    // Hazard resolution: freeze beats branch flush beats load-use bubble; reset blanks everything
    always_comb begin
        freeze       = (state != RUN) || (bus.dmem_req && !bus.dmem_ready);
        load_use     = bus.ex_mem_read && bus.ex_rd != '0 && (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
        br           = !freeze && bus.ex_branch_taken;
        lu           = !freeze && !bus.ex_branch_taken && load_use;
        bus.fwd_a    = rst ? 2'b00 : fwd_sel(bus.ex_rs1, bus.mem_rd, bus.wb_rd, bus.mem_reg_write, bus.wb_reg_write);
        bus.fwd_b    = rst ? 2'b00 : fwd_sel(bus.ex_rs2, bus.mem_rd, bus.wb_rd, bus.mem_reg_write, bus.wb_reg_write);
        bus.stall_f  = !rst && (freeze || lu);
        bus.stall_d  = !rst && (freeze || lu);
        bus.stall_e  = !rst && freeze;
        bus.stall_m  = !rst && freeze;
        bus.flush_d  = !rst && br;
        bus.flush_e  = !rst && (br || lu);
        bus.mem_err  = !rst && state == ERR;
    end

    // Saturating performance counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((freeze || lu) && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
            if (br && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus with a cycle-level reference model and literal spot checks
module tb_pipeline_hazard_ctrl;
    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam int TO  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 0;
    logic rst = 1;
    bit   go  = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    pipeline_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int ref_fwd(input int rs, input int m_rd, input int m_we, input int w_rd, input int w_we);
        if (rs == 0) return 0;
        if (m_we != 0 && m_rd == rs) return 2;
        if (w_we != 0 && w_rd == rs) return 1;
        return 0;
    endfunction

    // Reference model: mode 0 = running, 1 = waiting on memory, 2 = error; age = cycles waited so far
    int m_mode = 0, m_age = 0, m_stall = 0, m_flush = 0;

    always @(negedge clk) begin : model
        int e_fa, e_fb, e_sf, e_se, e_fd, e_fe, e_err;
        bit busy, hazard;
        if (go) begin
            if (rst) begin
                m_mode = 0; m_age = 0; m_stall = 0; m_flush = 0;
                e_fa = 0; e_fb = 0; e_sf = 0; e_se = 0; e_fd = 0; e_fe = 0; e_err = 0;
            end else begin
                busy   = (m_mode != 0) || (bus.dmem_req && !bus.dmem_ready);
                hazard = bus.ex_mem_read && bus.ex_rd != 0 && (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
                e_fa  = ref_fwd(bus.ex_rs1, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write);
                e_fb  = ref_fwd(bus.ex_rs2, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write);
                e_se  = busy;
                e_fd  = !busy && bus.ex_branch_taken;
                e_sf  = busy || (!bus.ex_branch_taken && hazard);
                e_fe  = !busy && (bus.ex_branch_taken || hazard);
                e_err = (m_mode == 2);
            end
            chk("fwd_a", bus.fwd_a, e_fa);
            chk("fwd_b", bus.fwd_b, e_fb);
            chk("stall_f", bus.stall_f, e_sf);
            chk("stall_d", bus.stall_d, e_sf);
            chk("stall_e", bus.stall_e, e_se);
            chk("stall_m", bus.stall_m, e_se);
            chk("flush_d", bus.flush_d, e_fd);
            chk("flush_e", bus.flush_e, e_fe);
            chk("mem_err", bus.mem_err, e_err);
            chk("stall_cycles", bus.stall_cycles, m_stall);
            chk("flush_events", bus.flush_events, m_flush);
            if (!rst) begin
                if (e_sf != 0) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
                if (e_fd != 0) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
                if (m_mode == 0 && bus.dmem_req && !bus.dmem_ready) begin
                    m_mode = 1; m_age = 1;
                end else if (m_mode == 1) begin
                    if (bus.dmem_ready) m_mode = 0;
                    else if (m_age == TO) m_mode = 2;
                    else m_age++;
                end else if (m_mode == 2 && bus.err_clr) begin
                    m_mode = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_rd = 0;
        bus.mem_rd = 0; bus.wb_rd = 0; bus.ex_mem_read = 0; bus.ex_branch_taken = 0;
        bus.mem_reg_write = 0; bus.wb_reg_write = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
        bus.err_clr = 0;
    endtask

    task automatic load_use(input int rd);
        bus.ex_mem_read = 1; bus.ex_rd = 5'(rd); bus.id_rs2 = 7;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        go = 1;
        step();
        #1;
        chk("reset stall_f", bus.stall_f, 0);
        chk("reset counters", bus.stall_cycles, 0);
        step();
        rst = 0;
        // forwarding priority and x0 suppression
        bus.ex_rs1 = 5; bus.ex_rs2 = 5; bus.mem_rd = 5; bus.wb_rd = 5;
        bus.mem_reg_write = 1; bus.wb_reg_write = 1;
        #1;
        chk("fwd mem prio a", bus.fwd_a, 2);
        chk("fwd mem prio b", bus.fwd_b, 2);
        step();
        bus.mem_reg_write = 0;
        #1;
        chk("fwd wb a", bus.fwd_a, 1);
        step();
        bus.mem_reg_write = 1; bus.ex_rs1 = 0; bus.mem_rd = 0; bus.wb_rd = 0;
        #1;
        chk("fwd x0", bus.fwd_a, 0);
        step();
        idle();
        // load-use bubble
        load_use(7);
        #1;
        chk("lu stall_f", bus.stall_f, 1);
        chk("lu flush_e", bus.flush_e, 1);
        chk("lu stall_e", bus.stall_e, 0);
        step();
        idle();
        #1;
        chk("lu count", bus.stall_cycles, 1);
        load_use(0);
        #1;
        chk("lu rd0 stall", bus.stall_f, 0);
        step();
        // branch wins over load-use
        load_use(7); bus.ex_branch_taken = 1;
        #1;
        chk("br flush_d", bus.flush_d, 1);
        chk("br stall_f", bus.stall_f, 0);
        step();
        idle();
        #1;
        chk("br flush count", bus.flush_events, 1);
        chk("br stall count", bus.stall_cycles, 1);
        // memory wait of three cycles then ready
        bus.dmem_req = 1;
        for (int i = 0; i < 3; i++) begin
            bus.ex_branch_taken = (i == 1);
            #1;
            chk("wait stall_m", bus.stall_m, 1);
            chk("wait no flush", bus.flush_d, 0);
            step();
        end
        bus.ex_branch_taken = 0; bus.dmem_ready = 1;
        #1;
        chk("ready cycle stall", bus.stall_f, 1);
        step();
        idle();
        #1;
        chk("wait released", bus.stall_f, 0);
        chk("wait count", bus.stall_cycles, 5);
        // timeout into error
        bus.dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("pre-timeout mem_err", bus.mem_err, 0);
            step();
        end
        bus.dmem_req = 0;
        #1;
        chk("err entered", bus.mem_err, 1);
        chk("err stall", bus.stall_e, 1);
        step();
        bus.dmem_ready = 1;
        step();
        bus.dmem_ready = 0; bus.err_clr = 1;
        #1;
        chk("err on clr cycle", bus.mem_err, 1);
        step();
        bus.err_clr = 0;
        #1;
        chk("err cleared", bus.mem_err, 0);
        chk("err unfrozen", bus.stall_f, 0);
        chk("counters kept stall", bus.stall_cycles, 12);
        chk("counters kept flush", bus.flush_events, 1);
        step();
        // asynchronous reset in the middle of a wait
        bus.dmem_req = 1;
        step();
        #1;
        chk("mid-wait stall", bus.stall_f, 1);
        #1;
        rst = 1;
        #1;
        chk("async rst stall", bus.stall_f, 0);
        chk("async rst count", bus.stall_cycles, 0);
        step();
        idle();
        rst = 0;
        // saturation of both counters
        for (int i = 0; i < 20; i++) begin
            load_use(7);
            step();
        end
        idle();
        #1;
        chk("stall saturate", bus.stall_cycles, SAT);
        bus.ex_branch_taken = 1;
        for (int i = 0; i < 20; i++) step();
        idle();
        #1;
        chk("flush saturate", bus.flush_events, SAT);
        chk("stall held", bus.stall_cycles, SAT);
        step();
        step();
        go = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
